iterative_alu: RTL and testbench

- Execute-stage ALU sitting directly downstream of ALUControlUnit: consumes its 4-bit `alu_op` code plus two operands and produces the result and branch condition.
- Add/sub/logic and branch compares complete in one cycle. Shifts run iteratively, one bit per cycle, instead of using a barrel shifter.
- A valid/ready handshake on both sides lets the control FSM stall while a shift is in progress.

---
 rtl/iterative_alu.sv | 147 ++++++++++++++
 tb/tb_iterative_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU fed by ALUControlUnit.
// Add/sub/logic ops and branch compares finish in one cycle; SLL/SRL are
// executed one bit per cycle so no barrel shifter is needed. Valid/ready
// handshakes on both sides let the control FSM stall while a shift runs.
module iterative_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_in_1,
    input  logic [DATA_WIDTH-1:0] alu_in_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  alu_bcond
);

    // Operation codes shared with ALUControlUnit.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_BLT  = 4'd9;
    localparam logic [3:0] OP_BGE  = 4'd10;
    localparam logic [3:0] OP_NONE = 4'd15;

    localparam int              SHW     = $clog2(DATA_WIDTH);
    localparam logic [SHW-1:0]  CNT_ONE = SHW'(1);
    localparam logic [SHW-1:0]  CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    bcond_q;
    logic [SHW-1:0]          cnt_q;
    logic                    shl_q;

    logic [DATA_WIDTH-1:0]   result_d;
    logic                    bcond_d;
    logic                    is_shift_d;
    logic [SHW-1:0]          shamt_d;

    assign shamt_d = alu_in_2[SHW-1:0];

    // Decode the request into its single-cycle result; shifts start from operand 1.
    always_comb begin
        result_d   = '0;
        bcond_d    = 1'b0;
        is_shift_d = 1'b0;
        case (alu_op)
            OP_ADD:  result_d = alu_in_1 + alu_in_2;
            OP_SUB:  result_d = alu_in_1 - alu_in_2;
            OP_AND:  result_d = alu_in_1 & alu_in_2;
            OP_OR:   result_d = alu_in_1 | alu_in_2;
            OP_XOR:  result_d = alu_in_1 ^ alu_in_2;
            OP_SLL, OP_SRL: begin
                result_d   = alu_in_1;
                is_shift_d = 1'b1;
            end
            OP_BEQ:  bcond_d = (alu_in_1 == alu_in_2);
            OP_BNE:  bcond_d = (alu_in_1 != alu_in_2);
            OP_BLT:  bcond_d = ($signed(alu_in_1) <  $signed(alu_in_2));
            OP_BGE:  bcond_d = ($signed(alu_in_1) >= $signed(alu_in_2));
            OP_NONE: begin
                result_d = '0;
                bcond_d  = 1'b0;
            end
            default: begin
                result_d = '0;
                bcond_d  = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake outputs and the iterative shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            bcond_q     <= 1'b0;
            cnt_q       <= '0;
            shl_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        result_q   <= result_d;
                        bcond_q    <= bcond_d;
                        shl_q      <= (alu_op == OP_SLL);
                        cnt_q      <= shamt_d;
                        in_ready_q <= 1'b0;
                        if (is_shift_d && (shamt_d != CNT_ZERO)) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= shl_q ? (result_q << 1) : (result_q >> 1);
                    cnt_q    <= cnt_q - CNT_ONE;
                    // The edge that takes the counter to zero also ends the shift.
                    if (cnt_q == CNT_ONE) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: single-cycle ops, branches, iterative
// shifts, output backpressure and asynchronous reset during a shift.
module tb_iterative_alu;

    localparam int W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_BLT  = 4'd9;
    localparam logic [3:0] OP_BGE  = 4'd10;
    localparam logic [3:0] OP_NONE = 4'd15;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_in_1;
    logic [W-1:0] alu_in_2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         alu_bcond;

    int tests = 0;
    int fails = 0;

    iterative_alu #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_bcond  (alu_bcond)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Issue one request with out_ready=1, measure latency, check result, check return to IDLE.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat,
                          input logic [W-1:0] exp_res, input logic exp_bc);
        int   lat;
        int   busy;
        chk({tag, " in_ready_before"}, W'(in_ready), 1);
        alu_op   = op;
        alu_in_1 = a;
        alu_in_2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_in_1 = ~a;
        alu_in_2 = ~b;
        alu_op   = OP_ADD;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            @(posedge clk); #1;
            lat++;
        end
        if (!in_ready) busy++;
        chk({tag, " latency"},   W'(lat),  W'(exp_lat));
        chk({tag, " busy"},      W'(busy), W'(exp_lat));
        chk({tag, " result"},    alu_result, exp_res);
        chk({tag, " bcond"},     W'(alu_bcond), W'(exp_bc));
        @(posedge clk); #1;
        chk({tag, " out_valid_drop"}, W'(out_valid), 0);
        chk({tag, " in_ready_back"},  W'(in_ready), 1);
    endtask

    initial begin
        int   stable;
        int   stale;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = OP_NONE;
        alu_in_1  = '0;
        alu_in_2  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset in_ready",  W'(in_ready), 1);
        chk("reset out_valid", W'(out_valid), 0);
        chk("reset result",    alu_result, 0);
        chk("reset bcond",     W'(alu_bcond), 0);

        run_op("add",   OP_ADD, 32'h0000_0005, 32'h0000_0003, 1, 32'h0000_0008, 1'b0);
        run_op("sub",   OP_SUB, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 1'b0);
        run_op("blt",   OP_BLT, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b1);
        run_op("bge",   OP_BGE, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b0);
        run_op("beq",   OP_BEQ, 32'h0000_0007, 32'h0000_0007, 1, 32'h0000_0000, 1'b1);
        run_op("bne",   OP_BNE, 32'h0000_0007, 32'h0000_0007, 1, 32'h0000_0000, 1'b0);
        run_op("bge_t", OP_BGE, 32'h0000_0001, 32'h8000_0000, 1, 32'h0000_0000, 1'b1);
        run_op("and",   OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 1'b0);
        run_op("or",    OP_OR,  32'hF000_0001, 32'h0F00_0010, 1, 32'hFF00_0011, 1'b0);
        run_op("sll31", OP_SLL, 32'h0000_0001, 32'h0000_001F, 32, 32'h8000_0000, 1'b0);
        run_op("srl4",  OP_SRL, 32'h8000_0000, 32'h0000_0004, 5, 32'h0800_0000, 1'b0);
        run_op("sll0",  OP_SLL, 32'h1234_5678, 32'h0000_0020, 1, 32'h1234_5678, 1'b0);
        run_op("srl1",  OP_SRL, 32'hFFFF_FFFF, 32'h0000_0001, 2, 32'h7FFF_FFFF, 1'b0);
        run_op("none",  OP_NONE, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 32'h0000_0000, 1'b0);
        run_op("undef", 4'd14,  32'hCAFE_0001, 32'h0000_0003, 1, 32'h0000_0000, 1'b0);

        // Backpressure: result held, new request ignored until IDLE.
        out_ready = 1'b0;
        alu_op    = OP_XOR;
        alu_in_1  = 32'hFF00_FF00;
        alu_in_2  = 32'h0F0F_0F0F;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        alu_op   = OP_ADD;
        alu_in_1 = 32'h0000_0002;
        alu_in_2 = 32'h0000_0003;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && !in_ready && alu_result === 32'hF00F_F00F && !alu_bcond) stable++;
            @(posedge clk); #1;
        end
        chk("bp stable_cycles", W'(stable), 10);
        chk("bp result", alu_result, 32'hF00F_F00F);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp idle out_valid", W'(out_valid), 0);
        chk("bp idle in_ready",  W'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp held out_valid", W'(out_valid), 1);
        chk("bp held result",    alu_result, 32'h0000_0005);
        @(posedge clk); #1;
        chk("bp held done", W'(in_ready), 1);

        // Asynchronous reset in the middle of a shift.
        alu_op   = OP_SLL;
        alu_in_1 = 32'h0000_0001;
        alu_in_2 = 32'h0000_0014;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rst mid_shift busy", W'(in_ready), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("rst async out_valid", W'(out_valid), 0);
        chk("rst async result",    alu_result, 0);
        chk("rst async in_ready",  W'(in_ready), 1);
        @(posedge clk); #3;
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("rst no_stale", W'(stale), 0);
        run_op("add_after_rst", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
